// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(32);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE
  } state_e;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Big-endian byte shift register; o_word is the word including the byte being shifted in.
module prog_loader_word_packer
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [BYTE_W-1:0]     i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_full
);

  localparam int unsigned BYTES = bytes_per_word(DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  assign o_word      = (r_shift << BYTE_W) | DATA_WIDTH'(i_byte);
  assign o_word_full = i_shift && (r_cnt == CNT_W'(BYTES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= o_word;
      r_cnt   <= o_word_full ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BYTE_W-1:0]     i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  state_e                r_state;
  logic                  r_rx_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic [CW-1:0]         r_words_left;

  logic                  w_accept;
  logic                  w_start_ok;
  logic                  w_shift;
  logic [CW-1:0]         w_len_words;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_full;

  assign w_accept   = i_rx_valid && r_rx_ready;
  assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_shift    = w_accept && (r_state == DATA);

  // Count byte of 0 or anything beyond the memory size means a full-depth load.
  always_comb begin
    w_len_words = CW'(DEPTH);
    if ((i_rx_data != 8'd0) && ({24'd0, i_rx_data} <= DEPTH)) begin
      w_len_words = CW'(i_rx_data);
    end
  end

  prog_loader_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_packer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_start_ok),
    .i_shift    (w_shift),
    .i_byte     (i_rx_data),
    .o_word     (w_word),
    .o_word_full(w_word_full)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_xor;
  logic              r_err;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_rx_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_words_left <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state    <= LEN;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_mem_addr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor      <= '0;
            r_err      <= 1'b0;
`endif
          end
        end
        LEN: begin
          if (w_accept) begin
            r_words_left <= w_len_words;
            r_state      <= DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ i_rx_data;
`endif
            if (w_word_full) begin
              r_state     <= WRITE;
              r_rx_ready  <= 1'b0;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_word;
            end
          end
        end
        WRITE: begin
          r_mem_we     <= 1'b0;
          r_mem_addr   <= r_mem_addr + ADDR_WIDTH'(1);
          r_words_left <= r_words_left - CW'(1);
          if (r_words_left == CW'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_state    <= CHK;
            r_rx_ready <= 1'b1;
`else
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state    <= DATA;
            r_rx_ready <= 1'b1;
          end
        end
        CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (w_accept) begin
            r_err      <= (i_rx_data != r_xor);
            r_state    <= DONE;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
`else
          r_state    <= DONE;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
`endif
        end
        default: begin
          r_state    <= IDLE;
          r_rx_ready <= 1'b0;
          r_mem_we   <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized loads checked against a queue-based model of the byte stream.
module tb_prog_loader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int long_pulse = 0;
  logic we_prev = 1'b0;

  logic [7:0]    tx[$];
  logic [AW-1:0] act_addr[$];
  logic [DW-1:0] act_data[$];

  always #5 clk = ~clk;

  prog_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  // Write-port monitor: records every write and flags pulses wider than one cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
      if (we_prev) long_pulse <= long_pulse + 1;
    end
    we_prev <= mem_we;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte has been taken.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 200; k++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int gap);
    if (gap > 0) repeat (gap) @(negedge clk);
  endtask

  // Runs one load of the bytes in tx (padded with random bytes to the clamped length).
  task automatic run_load(input logic [7:0] n, input int gap, input bit mid_start,
                          input bit corrupt);
    int unsigned words;
    int          base;
    int          lp0;
    logic [7:0]  x;
    logic [DW-1:0] ew;
    bit          exp_err;
    words = (n == 8'd0 || n > DEPTH) ? DEPTH : int'(n);
    base  = act_data.size();
    lp0   = long_pulse;
    x     = 8'd0;
    while (tx.size() < words * NB) tx.push_back(8'($urandom_range(0, 255)));

    pulse_start();
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("done_after_start", {63'd0, done}, 64'd0);
    send_byte(n);
    idle(gap);
    for (int i = 0; i < int'(words * NB); i++) begin
      x ^= tx[i];
      send_byte(tx[i]);
      if (i % NB == NB - 1) begin
        chk("we_latency", {63'd0, mem_we}, 64'd1);
        chk("we_addr", 64'(mem_addr), 64'((i / NB) % DEPTH));
      end
      if (mid_start && i == 1) pulse_start();
      idle(gap);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(corrupt ? ~x : x);
`endif
    for (int k = 0; k < 50; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done", {63'd0, done}, 64'd1);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("ready_at_done", {63'd0, rx_ready}, 64'd0);
    chk("we_at_done", {63'd0, mem_we}, 64'd0);
    chk("addr_at_done", 64'(mem_addr), 64'(words % DEPTH));
    chk("write_count", 64'(act_data.size() - base), 64'(words));
    for (int j = 0; j < int'(words); j++) begin
      ew = '0;
      for (int b = 0; b < int'(NB); b++) ew = (ew << 8) | DW'(tx[j * NB + b]);
      if (base + j < act_data.size()) begin
        chk("wdata", 64'(act_data[base + j]), 64'(ew));
        chk("waddr", 64'(act_addr[base + j]), 64'(j % DEPTH));
      end
    end
    chk("we_width", 64'(long_pulse - lp0), 64'd0);
    exp_err = corrupt & CK_EN;
    chk("err", {63'd0, err}, {63'd0, exp_err});
    tx.delete();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, rx_ready}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word load, then the same stream with a stalled source.
    tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(8'h02, 0, 1'b0, 1'b0);
    tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(8'h02, 3, 1'b0, 1'b0);

    // Full depth with wrap, and an oversized count clamped to full depth.
    run_load(8'h00, 0, 1'b0, 1'b0);
    run_load(8'h50, 0, 1'b0, 1'b0);

    // Random length and stalls, with a start pulse in the middle of DATA.
    run_load(8'($urandom_range(1, 64)), int'($urandom_range(0, 2)), 1'b1, 1'b0);
    run_load(8'($urandom_range(2, 64)), int'($urandom_range(0, 2)), 1'b0, 1'b0);

    // Restart from DONE.
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(8'h01, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a word.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    chk("pre_rst_ready", {63'd0, rx_ready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {63'd0, rx_ready}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    chk("async_rst_we", {63'd0, mem_we}, 64'd0);
    chk("async_rst_addr", 64'(mem_addr), 64'd0);
    chk("async_rst_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_load(8'h01, 0, 1'b0, 1'b0);

    if (CK_EN) begin
      tx = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_load(8'h01, 0, 1'b0, 1'b0);
      tx = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_load(8'h01, 1, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
